reg_scoreboard: RTL

Register-file scoreboard for the pipelined RISC-V core. It tracks which architectural registers have an issued write that has not yet reached the register file. It stalls issue on RAW hazards (source still pending) and WAW hazards (destination still pending). It sits between decode/issue, which sets pending bits, and the writeback port that drives the register file write, which clears them.

---
 rtl/reg_scoreboard.sv | 116 +++++++++++
 1 files changed

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: pending-write scoreboard for the RISC-V issue stage.
// Tracks architectural registers with an issued, not-yet-written-back write.
// Issue stalls on RAW hazards (a source is pending) and WAW hazards (the
// destination is pending). Writeback clears the pending bit.
// Optional feature macro: SB_WB_BYPASS_EN. When it is defined, a register
// being written back this cycle counts as ready. The register file writes on
// negedge, so the value is in place before the consumer reads it.
`timescale 1ns/1ps
module reg_scoreboard #(
    parameter int NREG = 32,
    parameter int CNTW = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            issue_valid,
    input  logic            issue_wr,
    input  logic [4:0]      issue_rd,
    input  logic [4:0]      issue_rs1,
    input  logic [4:0]      issue_rs2,
    output logic            issue_ready,
    output logic            stall,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    output logic [NREG-1:0] busy_vec,
    output logic [CNTW-1:0] pending_cnt,
    output logic            wb_err
);

    logic [NREG-1:0] busy_q, busy_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;

    logic [NREG-1:0] eff_busy;
    logic [NREG-1:0] wb_sel;
    logic [NREG-1:0] set_vec;
    logic [NREG-1:0] clr_vec;
    logic [NREG-1:0] rs1_hit;
    logic [NREG-1:0] rs2_hit;
    logic [NREG-1:0] rd_hit;

    logic raw, waw, accept, set_any, clr_any, wb_miss;

    // Per-register decode. Each register compares the issue and writeback
    // indices against its own number, so no wide muxes are needed. Entry 0 is
    // x0: it is never busy, never set and never cleared.
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                assign wb_sel[gi]   = 1'b0;
                assign eff_busy[gi] = 1'b0;
                assign set_vec[gi]  = 1'b0;
                assign clr_vec[gi]  = 1'b0;
            end else begin : g_arch
                assign wb_sel[gi] = wb_valid && (wb_rd == 5'(gi));
`ifdef SB_WB_BYPASS_EN
                // Writeback this cycle lands before the consumer reads.
                assign eff_busy[gi] = busy_q[gi] && !wb_sel[gi];
`else
                assign eff_busy[gi] = busy_q[gi];
`endif
                assign set_vec[gi] = accept && issue_wr && (issue_rd == 5'(gi));
                assign clr_vec[gi] = wb_sel[gi] && busy_q[gi];
            end
            assign rs1_hit[gi] = eff_busy[gi] && (issue_rs1 == 5'(gi));
            assign rs2_hit[gi] = eff_busy[gi] && (issue_rs2 == 5'(gi));
            assign rd_hit[gi]  = eff_busy[gi] && (issue_rd  == 5'(gi));
        end
    endgenerate

    assign raw         = (|rs1_hit) || (|rs2_hit);
    assign waw         = issue_wr && (|rd_hit);
    assign issue_ready = !(raw || waw);
    assign stall       = issue_valid && !issue_ready;
    assign accept      = issue_valid && issue_ready && !flush;

    assign set_any = |set_vec;
    assign clr_any = |clr_vec;

    // A nonzero writeback that matched no pending bit is a protocol error.
    assign wb_miss = wb_valid && (wb_rd != 5'd0) && !clr_any;

    // Next state: flush wins. Otherwise clear first, then set, so a
    // same-register set and clear leaves the bit set with no net count change.
    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        err_d  = err_q;
        if (flush) begin
            busy_d = '0;
            cnt_d  = '0;
        end else begin
            busy_d = (busy_q & ~clr_vec) | set_vec;
            cnt_d  = cnt_q + CNTW'(set_any) - CNTW'(clr_any);
            err_d  = err_q || wb_miss;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    assign busy_vec    = busy_q;
    assign pending_cnt = cnt_q;
    assign wb_err      = err_q;

endmodule
